// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH register file with one operate port and two
// combinational read ports.
//
// The operate port applies LOAD / INC / DEC / CLR to reg[wr_addr] on the
// rising clk edge when wr_en is high. The registered flags describe the
// result of the last accepted operation:
//   carry - INC wrapped from all-ones, or DEC wrapped from zero
//   zero  - the result equalled 0
// With ZERO_REG=1, register 0 is hard-wired to 0. Operations aimed at it
// still compute a result and update the flags, but nothing is stored.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   wr_en, op, wr_addr   operation strobe, opcode, target register
//   wr_data              operand, used by LOAD only
//   rd_addr_a/rd_data_a  read port A (combinational)
//   rd_addr_b/rd_data_b  read port B (combinational)
//   carry, zero          flags from the last accepted operation

// One storage word. This is a plain enabled flop with async clear.
module register_bank_cell #(
  parameter int WIDTH = 8
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module register_bank #(
  parameter  int WIDTH    = 8,
  parameter  int DEPTH    = 8,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       op,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             carry,
  output logic             zero
);

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] data;
  } result_t;

  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [WIDTH-1:0]            old;
  result_t                     res;

  // With ZERO_REG set, regs[0] is constant 0. An operation on address 0
  // therefore computes from 0, which gives the flag behaviour expected of
  // a hard-wired zero register.
  assign old = regs[wr_addr];

  // Perform the add or subtract one bit wider than the data. The extra top
  // bit is then exactly the wrap indicator: the carry out of all-ones for
  // INC, and the borrow out of zero for DEC.
  always_comb begin
    res = '0;
    case (op)
      OP_LOAD: res.data = wr_data;
      OP_INC:  {res.carry, res.data} = {1'b0, old} + (WIDTH+1)'(1);
      OP_DEC:  {res.carry, res.data} = {1'b0, old} - (WIDTH+1)'(1);
      OP_CLR:  res = '0;
      default: res = '0;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    if (ZERO_REG != 0 && i == 0) begin : g_hard0
      assign regs[i] = '0;
    end else begin : g_cell
      register_bank_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en && (wr_addr == AW'(i))),
        .d     (res.data),
        .q     (regs[i])
      );
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (wr_en) begin
      carry <= res.carry;
      zero  <= (res.data == '0);
    end
  end

  // The reads are combinational, so a write issued in the same cycle only
  // becomes visible after the edge.
  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];

endmodule

// File: tb/tb_register_bank.sv
`timescale 1ns/1ps
module tb_register_bank;

  localparam int W = 8;
  localparam int A = 3;
  localparam logic [1:0] LOAD = 2'b00, INC = 2'b01, DEC = 2'b10, CLR = 2'b11;

  logic clk, rst_n;
  // dut 0: ZERO_REG=0
  logic         wr_en0;
  logic [1:0]   op0;
  logic [A-1:0] wa0, ra0, rb0;
  logic [W-1:0] wd0, rda0, rdb0;
  logic         c0, z0;
  // dut 1: ZERO_REG=1
  logic         wr_en1;
  logic [1:0]   op1;
  logic [A-1:0] wa1, ra1, rb1;
  logic [W-1:0] wd1, rda1, rdb1;
  logic         c1, z1;

  int total = 0;
  int bad   = 0;

  register_bank #(.WIDTH(W), .DEPTH(8), .ZERO_REG(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en0), .op(op0), .wr_addr(wa0),
    .wr_data(wd0), .rd_addr_a(ra0), .rd_data_a(rda0), .rd_addr_b(rb0),
    .rd_data_b(rdb0), .carry(c0), .zero(z0)
  );

  register_bank #(.WIDTH(W), .DEPTH(8), .ZERO_REG(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en1), .op(op1), .wr_addr(wa1),
    .wr_data(wd1), .rd_addr_a(ra1), .rd_data_a(rda1), .rd_addr_b(rb1),
    .rd_data_b(rdb1), .carry(c1), .zero(z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation on the selected DUT. Inputs change on the negedge,
  // and the task returns 1ns after the posedge with wr_en dropped.
  task automatic do_op(input int sel, input logic [1:0] o, input logic [A-1:0] a,
                       input logic [W-1:0] d);
    @(negedge clk);
    if (sel == 0) begin wr_en0 = 1'b1; op0 = o; wa0 = a; wd0 = d; end
    else          begin wr_en1 = 1'b1; op1 = o; wa1 = a; wd1 = d; end
    @(posedge clk); #1;
    wr_en0 = 1'b0; wr_en1 = 1'b0;
  endtask

  task automatic test_reset;
    ra0 = 3'd3; rb0 = 3'd5;
    #1;
    total++; if (rda0 !== 8'h00) begin bad++; $display("FAIL reset_rda got=%h want=00", rda0); end
    total++; if (rdb0 !== 8'h00) begin bad++; $display("FAIL reset_rdb got=%h want=00", rdb0); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", c0); end
    total++; if (z0 !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", z0); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load;
    do_op(0, LOAD, 3'd3, 8'h5A);
    ra0 = 3'd3; #1;
    total++; if (rda0 !== 8'h5A) begin bad++; $display("FAIL load_data got=%h want=5a", rda0); end
    total++; if (z0 !== 1'b0) begin bad++; $display("FAIL load_zero got=%b want=0", z0); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL load_carry got=%b want=0", c0); end
  endtask

  task automatic test_inc_wrap;
    do_op(0, LOAD, 3'd2, 8'hFF);
    do_op(0, INC, 3'd2, 8'h00);
    ra0 = 3'd2; #1;
    total++; if (rda0 !== 8'h00) begin bad++; $display("FAIL inc_wrap_data got=%h want=00", rda0); end
    total++; if (c0 !== 1'b1) begin bad++; $display("FAIL inc_wrap_carry got=%b want=1", c0); end
    total++; if (z0 !== 1'b1) begin bad++; $display("FAIL inc_wrap_zero got=%b want=1", z0); end
    do_op(0, INC, 3'd2, 8'h00);
    #1;
    total++; if (rda0 !== 8'h01) begin bad++; $display("FAIL inc_data got=%h want=01", rda0); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL inc_carry got=%b want=0", c0); end
    total++; if (z0 !== 1'b0) begin bad++; $display("FAIL inc_zero got=%b want=0", z0); end
  endtask

  task automatic test_dec_wrap;
    do_op(0, LOAD, 3'd4, 8'h66);
    do_op(0, CLR, 3'd4, 8'h77);
    rb0 = 3'd4; #1;
    total++; if (rdb0 !== 8'h00) begin bad++; $display("FAIL clr_data got=%h want=00", rdb0); end
    total++; if (z0 !== 1'b1) begin bad++; $display("FAIL clr_zero got=%b want=1", z0); end
    do_op(0, DEC, 3'd4, 8'h00);
    #1;
    total++; if (rdb0 !== 8'hFF) begin bad++; $display("FAIL dec_wrap_data got=%h want=ff", rdb0); end
    total++; if (c0 !== 1'b1) begin bad++; $display("FAIL dec_wrap_carry got=%b want=1", c0); end
    total++; if (z0 !== 1'b0) begin bad++; $display("FAIL dec_wrap_zero got=%b want=0", z0); end
    do_op(0, DEC, 3'd4, 8'h00);
    #1;
    total++; if (rdb0 !== 8'hFE) begin bad++; $display("FAIL dec_data got=%h want=fe", rdb0); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL dec_carry got=%b want=0", c0); end
  endtask

  task automatic test_read_during_write;
    do_op(0, LOAD, 3'd1, 8'h10);
    @(negedge clk);
    wr_en0 = 1'b1; op0 = LOAD; wa0 = 3'd1; wd0 = 8'h33;
    ra0 = 3'd1; rb0 = 3'd1;
    #1;
    total++; if (rda0 !== 8'h10) begin bad++; $display("FAIL rdw_old_a got=%h want=10", rda0); end
    total++; if (rdb0 !== 8'h10) begin bad++; $display("FAIL rdw_old_b got=%h want=10", rdb0); end
    @(posedge clk); #1;
    wr_en0 = 1'b0;
    total++; if (rda0 !== 8'h33) begin bad++; $display("FAIL rdw_new_a got=%h want=33", rda0); end
    total++; if (rdb0 !== 8'h33) begin bad++; $display("FAIL rdw_new_b got=%h want=33", rdb0); end
  endtask

  task automatic test_no_write;
    do_op(0, CLR, 3'd5, 8'h00);          // zero=1, carry=0
    @(negedge clk);
    wr_en0 = 1'b0; op0 = LOAD; wa0 = 3'd5; wd0 = 8'h44;
    @(posedge clk); #1;
    ra0 = 3'd5; #1;
    total++; if (rda0 !== 8'h00) begin bad++; $display("FAIL nowr_data got=%h want=00", rda0); end
    total++; if (z0 !== 1'b1) begin bad++; $display("FAIL nowr_zero got=%b want=1", z0); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL nowr_carry got=%b want=0", c0); end
  endtask

  task automatic test_zero_reg;
    ra1 = 3'd0; rb1 = 3'd0;
    do_op(1, LOAD, 3'd0, 8'h07);
    #1;
    total++; if (rda1 !== 8'h00) begin bad++; $display("FAIL zr_load_a got=%h want=00", rda1); end
    total++; if (rdb1 !== 8'h00) begin bad++; $display("FAIL zr_load_b got=%h want=00", rdb1); end
    total++; if (z1 !== 1'b0) begin bad++; $display("FAIL zr_load_zero got=%b want=0", z1); end
    do_op(1, INC, 3'd0, 8'h00);
    #1;
    total++; if (rda1 !== 8'h00) begin bad++; $display("FAIL zr_inc_data got=%h want=00", rda1); end
    total++; if (c1 !== 1'b0) begin bad++; $display("FAIL zr_inc_carry got=%b want=0", c1); end
    total++; if (z1 !== 1'b0) begin bad++; $display("FAIL zr_inc_zero got=%b want=0", z1); end
    do_op(1, DEC, 3'd0, 8'h00);
    #1;
    total++; if (c1 !== 1'b1) begin bad++; $display("FAIL zr_dec_carry got=%b want=1", c1); end
    total++; if (z1 !== 1'b0) begin bad++; $display("FAIL zr_dec_zero got=%b want=0", z1); end
    do_op(1, CLR, 3'd0, 8'h00);
    #1;
    total++; if (z1 !== 1'b1) begin bad++; $display("FAIL zr_clr_zero got=%b want=1", z1); end
    do_op(1, LOAD, 3'd7, 8'h80);
    rb1 = 3'd7; #1;
    total++; if (rdb1 !== 8'h80) begin bad++; $display("FAIL zr_reg7 got=%h want=80", rdb1); end
    total++; if (rda1 !== 8'h00) begin bad++; $display("FAIL zr_reg0_a got=%h want=00", rda1); end
  endtask

  task automatic test_async_reset;
    for (int i = 1; i < 8; i++) do_op(0, LOAD, 3'(i), 8'(i * 17 + 1));
    do_op(0, LOAD, 3'd0, 8'h00);
    do_op(0, DEC, 3'd0, 8'h00);          // reg0=ff, carry=1
    ra0 = 3'd6; #1;
    total++; if (rda0 !== 8'h67) begin bad++; $display("FAIL pre_rst_reg6 got=%h want=67", rda0); end
    total++; if (c0 !== 1'b1) begin bad++; $display("FAIL pre_rst_carry got=%b want=1", c0); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra0 = 3'(i); rb0 = 3'(7 - i);
      #0.2;
      total++; if (rda0 !== 8'h00) begin bad++; $display("FAIL arst_a[%0d] got=%h want=00", i, rda0); end
      total++; if (rdb0 !== 8'h00) begin bad++; $display("FAIL arst_b[%0d] got=%h want=00", 7 - i, rdb0); end
    end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL arst_carry got=%b want=0", c0); end
    total++; if (z0 !== 1'b0) begin bad++; $display("FAIL arst_zero got=%b want=0", z0); end
  endtask

  task automatic test_reset_edge;
    // rst_n is still low here
    @(negedge clk);
    wr_en0 = 1'b1; op0 = DEC; wa0 = 3'd3; wd0 = 8'h00;
    ra0 = 3'd3;
    @(posedge clk); #1;
    total++; if (rda0 !== 8'h00) begin bad++; $display("FAIL rst_edge_data got=%h want=00", rda0); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL rst_edge_carry got=%b want=0", c0); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    wr_en0 = 1'b0;
    total++; if (rda0 !== 8'hFF) begin bad++; $display("FAIL post_rst_data got=%h want=ff", rda0); end
    total++; if (c0 !== 1'b1) begin bad++; $display("FAIL post_rst_carry got=%b want=1", c0); end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en0 = 1'b0; op0 = LOAD; wa0 = '0; wd0 = '0; ra0 = '0; rb0 = '0;
    wr_en1 = 1'b0; op1 = LOAD; wa1 = '0; wd1 = '0; ra1 = '0; rb1 = '0;
    #12;
    test_reset;
    test_load;
    test_inc_wrap;
    test_dec_wrap;
    test_read_during_write;
    test_no_write;
    test_zero_reg;
    test_async_reset;
    test_reset_edge;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
